// File: rtl/decode_pipe_ctrl_pkg.sv
// Shared definitions for the decode stage controller.
// Holds the opcode constants, ALU control and shift encodings, the FSM state
// type, the packed control bundle and helpers that map funct3 to ALU/shift codes.
package decode_pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       jal;
    logic       jalr;
    logic       illegal;
    logic [3:0] alu_ctrl;
    logic [2:0] compare;
    logic [1:0] shift;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // alt selects SUB (funct3=0) or SRA (funct3=5); the caller decides when alt applies.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] a;
    case (f3)
      3'd0:    a = alt ? ALU_SUB : ALU_ADD;
      3'd1:    a = ALU_SLL;
      3'd2:    a = ALU_SLT;
      3'd3:    a = ALU_SLTU;
      3'd4:    a = ALU_XOR;
      3'd5:    a = alt ? ALU_SRA : ALU_SRL;
      3'd6:    a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  function automatic logic [1:0] shift_from_funct3(input logic [2:0] f3, input logic alt);
    logic [1:0] s;
    case (f3)
      3'd1:    s = SH_SLL;
      3'd5:    s = alt ? SH_SRA : SH_SRL;
      default: s = SH_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decode_pipe_ctrl_decode.sv
// instr_decode_comb: purely combinational instruction decoder.
// Ports: instr_i (32-bit instruction in), ctrl_o (packed ctrl_t bundle out).
// MEXT_EN=1 decodes R-type funct7=7'h01 as multiply, otherwise it is illegal.
module instr_decode_comb
  import decode_pipe_ctrl_pkg::*;
#(
  parameter int MEXT_EN = 0
) (
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       sra_alt;
  ctrl_t      d;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  // For I-ALU, bit 30 only distinguishes SRAI from SRLI; ADDI has no SUB form.
  assign sra_alt = instr_i[30] && (funct3 == 3'd5);

  always_comb begin
    d     = '0;
    d.rd  = instr_i[11:7];
    d.rs1 = instr_i[19:15];
    d.rs2 = instr_i[24:20];
    case (opcode)
      OP_R: begin
        d.reg_write = 1'b1;
        if (funct7 == 7'h01) begin
          if (MEXT_EN != 0) d.alu_ctrl = ALU_MUL;
          else              d.illegal  = 1'b1;
        end else begin
          d.alu_ctrl = alu_from_funct3(funct3, funct7[5]);
          d.shift    = shift_from_funct3(funct3, funct7[5]);
        end
      end
      OP_I: begin
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
        d.alu_ctrl  = alu_from_funct3(funct3, sra_alt);
        d.shift     = shift_from_funct3(funct3, sra_alt);
      end
      OP_LOAD: begin
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
        d.mem_read  = 1'b1;
        d.alu_ctrl  = ALU_ADD;
      end
      OP_STORE: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.alu_ctrl  = ALU_ADD;
      end
      OP_BRANCH: begin
        d.branch   = 1'b1;
        d.alu_ctrl = ALU_SUB;
        d.compare  = funct3;
      end
      OP_JAL: begin
        d.reg_write = 1'b1;
        d.jal       = 1'b1;
        d.alu_ctrl  = ALU_ADD;
      end
      OP_JALR: begin
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
        d.jalr      = 1'b1;
        d.alu_ctrl  = ALU_ADD;
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal words carry no side effects downstream.
    if (d.illegal) begin
      d.reg_write = 1'b0;
      d.alu_ctrl  = '0;
      d.shift     = '0;
    end
    if (d.rd == 5'd0) d.reg_write = 1'b0;
  end

  assign ctrl_o = d;

endmodule

// File: rtl/decode_pipe_ctrl.sv
// decode_pipe_ctrl: decode-stage pipeline register with flush FSM and load-use
// hazard bubble insertion.
// Ports: clk_i/rst_i (clock, sync active-high reset); instr_i/instr_valid_i/
// instr_ready_o (fetch handshake); ex_ready_i (EX consumes bundle);
// redirect_i (taken branch/jump, squash younger work); ctrl_valid_o plus the
// registered control flags, ALU/compare/shift codes and register addresses.
module decode_pipe_ctrl
  import decode_pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int HAZARD_EN    = 1,
  parameter int MEXT_EN      = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        ex_ready_i,
  input  logic        redirect_i,
  output logic        ctrl_valid_o,
  output logic        RegWrite_o,
  output logic        ALUsrc_o,
  output logic        Branch_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        J_o,
  output logic        Jalr_o,
  output logic        illegal_o,
  output logic [3:0]  ALUControl_o,
  output logic [2:0]  Compare_o,
  output logic [1:0]  Shift_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  localparam logic       HAZARD_ON  = (HAZARD_EN != 0);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec;
  ctrl_t             out_q;
  logic              valid_q;
  state_t            state_q;
  logic [1:0]        fcnt_q;
  logic              uses_rs2;
  logic              bubble;
  logic              accept;

  instr_decode_comb #(.MEXT_EN(MEXT_EN)) u_decode (
    .instr_i (instr_i),
    .ctrl_o  (dec_bits)
  );

  assign dec = dec_bits;

  assign uses_rs2 = (instr_i[6:0] == OP_R) || (instr_i[6:0] == OP_STORE) ||
                    (instr_i[6:0] == OP_BRANCH);

  // A load sitting in the output register must reach EX before a consumer of its rd.
  assign bubble = HAZARD_ON && valid_q && out_q.mem_read && (out_q.rd != 5'd0) &&
                  ((out_q.rd == instr_i[19:15]) || ((out_q.rd == instr_i[24:20]) && uses_rs2));

  // While flushing, fetch is drained unconditionally so squashed words leave quickly.
  assign instr_ready_o = (state_q == ST_FLUSH) ||
                         (!bubble && (!valid_q || ex_ready_i));
  assign accept = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (redirect_i) begin
      valid_q <= 1'b0;
      state_q <= ST_FLUSH;
      fcnt_q  <= FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Slot is free or being consumed: load the new bundle or a bubble.
          if (!valid_q || ex_ready_i) begin
            valid_q <= accept;
            if (accept) out_q <= dec;
          end
        end
        default: begin
          if (instr_valid_i) begin
            if (fcnt_q == 2'd0) state_q <= ST_RUN;
            else                fcnt_q  <= fcnt_q - 2'd1;
          end
        end
      endcase
    end
  end

  assign ctrl_valid_o = valid_q;
  assign RegWrite_o   = out_q.reg_write;
  assign ALUsrc_o     = out_q.alu_src;
  assign Branch_o     = out_q.branch;
  assign MemRead_o    = out_q.mem_read;
  assign MemWrite_o   = out_q.mem_write;
  assign J_o          = out_q.jal;
  assign Jalr_o       = out_q.jalr;
  assign illegal_o    = out_q.illegal;
  assign ALUControl_o = out_q.alu_ctrl;
  assign Compare_o    = out_q.compare;
  assign Shift_o      = out_q.shift;
  assign rd_o         = out_q.rd;
  assign rs1_o        = out_q.rs1;
  assign rs2_o        = out_q.rs2;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Bench for decode_pipe_ctrl. Two instances share all inputs:
//   dut 0: FLUSH_CYCLES=2, HAZARD_EN=1, MEXT_EN=0
//   dut 1: FLUSH_CYCLES=1, HAZARD_EN=0, MEXT_EN=1
// Directed scenario tasks use constant expectations; the random task compares
// against a transaction-level reference model that tracks both instances.
module tb_decode_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_ready;
  logic        redirect;

  logic       rdy [2];
  logic       vld [2];
  logic       rw  [2];
  logic       src [2];
  logic       br  [2];
  logic       mr  [2];
  logic       mw  [2];
  logic       jj  [2];
  logic       jr  [2];
  logic       ill [2];
  logic [3:0] alu [2];
  logic [2:0] cmp [2];
  logic [1:0] sh  [2];
  logic [4:0] rd  [2];
  logic [4:0] rs1 [2];
  logic [4:0] rs2 [2];
  logic [32:0] obs [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_pipe_ctrl #(.FLUSH_CYCLES(2), .HAZARD_EN(1), .MEXT_EN(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
    .instr_ready_o(rdy[0]), .ex_ready_i(ex_ready), .redirect_i(redirect),
    .ctrl_valid_o(vld[0]), .RegWrite_o(rw[0]), .ALUsrc_o(src[0]), .Branch_o(br[0]),
    .MemRead_o(mr[0]), .MemWrite_o(mw[0]), .J_o(jj[0]), .Jalr_o(jr[0]),
    .illegal_o(ill[0]), .ALUControl_o(alu[0]), .Compare_o(cmp[0]), .Shift_o(sh[0]),
    .rd_o(rd[0]), .rs1_o(rs1[0]), .rs2_o(rs2[0])
  );

  decode_pipe_ctrl #(.FLUSH_CYCLES(1), .HAZARD_EN(0), .MEXT_EN(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
    .instr_ready_o(rdy[1]), .ex_ready_i(ex_ready), .redirect_i(redirect),
    .ctrl_valid_o(vld[1]), .RegWrite_o(rw[1]), .ALUsrc_o(src[1]), .Branch_o(br[1]),
    .MemRead_o(mr[1]), .MemWrite_o(mw[1]), .J_o(jj[1]), .Jalr_o(jr[1]),
    .illegal_o(ill[1]), .ALUControl_o(alu[1]), .Compare_o(cmp[1]), .Shift_o(sh[1]),
    .rd_o(rd[1]), .rs1_o(rs1[1]), .rs2_o(rs2[1])
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_obs
    assign obs[gi] = {vld[gi], rw[gi], src[gi], br[gi], mr[gi], mw[gi], jj[gi], jr[gi],
                      ill[gi], alu[gi], cmp[gi], sh[gi], rd[gi], rs1[gi], rs2[gi]};
  end

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_BEQ  = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_ADDI = 32'h00100393; // addi x7,x0,1
  localparam logic [31:0] I_XOR  = 32'h0020C433; // xor  x8,x1,x2
  localparam logic [31:0] I_ILL  = 32'h0000057F; // opcode 7F, rd=x10
  localparam logic [31:0] I_MUL  = 32'h022084B3; // mul  x9,x1,x2

  // ---------------- reference model ----------------
  // Bundle layout: {RegWrite,ALUsrc,Branch,MemRead,MemWrite,J,Jalr,illegal,
  //                 ALUControl[3:0],Compare[2:0],Shift[1:0],rd,rs1,rs2}
  function automatic logic [31:0] ref_decode(input logic [31:0] ins, input bit mext);
    logic [3:0] tbl [8];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit rwb, srcb, brb, mrb, mwb, jb, jrb, illb, alt;
    logic [3:0] a;
    logic [2:0] c;
    logic [1:0] s;
    tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    {rwb, srcb, brb, mrb, mwb, jb, jrb, illb} = '0;
    a = 4'b0000;
    c = 3'b000;
    s = 2'b00;
    alt = ins[30];
    if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h33 && f7 == 7'h01) begin
        if (mext) a = 4'b1010;
        else      illb = 1'b1;
      end else begin
        a = tbl[f3];
        if (op == 7'h33 && f3 == 3'd0 && alt) a = 4'b0110;
        if (f3 == 3'd5 && alt) a = 4'b0111;
        s = (f3 == 3'd1) ? 2'b01 : (f3 == 3'd5) ? (alt ? 2'b11 : 2'b10) : 2'b00;
      end
      rwb  = !illb;
      srcb = (op == 7'h13);
    end else begin
      case (op)
        7'h03: begin rwb = 1; srcb = 1; mrb = 1; a = 4'b0010; end
        7'h23: begin srcb = 1; mwb = 1; a = 4'b0010; end
        7'h63: begin brb = 1; a = 4'b0110; c = f3; end
        7'h6F: begin rwb = 1; jb = 1; a = 4'b0010; end
        7'h67: begin rwb = 1; srcb = 1; jrb = 1; a = 4'b0010; end
        default: illb = 1'b1;
      endcase
    end
    if (ins[11:7] == 5'd0) rwb = 1'b0;
    return {rwb, srcb, brb, mrb, mwb, jb, jrb, illb, a, c, s, ins[11:7], ins[19:15], ins[24:20]};
  endfunction

  function automatic int p_flush(input int k);  return (k == 0) ? 2 : 1; endfunction
  function automatic bit p_hazard(input int k); return (k == 0); endfunction
  function automatic bit p_mext(input int k);   return (k == 1); endfunction

  bit          m_valid [2] = '{0, 0};
  logic [31:0] m_bundle[2] = '{32'h0, 32'h0};
  int          m_flush [2] = '{0, 0};   // accepts still to be discarded

  function automatic bit exp_ready(input int k);
    bit hz;
    logic [4:0] r;
    if (m_flush[k] > 0) return 1'b1;
    r  = m_bundle[k][14:10];
    hz = p_hazard(k) && m_valid[k] && m_bundle[k][28] && (r != 5'd0) &&
         ((r == instr[19:15]) ||
          ((r == instr[24:20]) && (instr[6:0] == 7'h33 || instr[6:0] == 7'h23 || instr[6:0] == 7'h63)));
    return !hz && (!m_valid[k] || ex_ready);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_valid[k]  <= 1'b0;
        m_bundle[k] <= '0;
        m_flush[k]  <= 0;
      end else if (redirect) begin
        m_valid[k] <= 1'b0;
        m_flush[k] <= p_flush(k);
      end else if (m_flush[k] > 0) begin
        if (instr_valid) m_flush[k] <= m_flush[k] - 1;
      end else if (!m_valid[k] || ex_ready) begin
        if (instr_valid && exp_ready(k)) begin
          m_valid[k]  <= 1'b1;
          m_bundle[k] <= ref_decode(instr, p_mext(k));
        end else begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 8);
    case (sel)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      6: w[6:0] = 7'h67;
      7: w[6:0] = 7'h7F;
      default: w[6:0] = 7'h37;
    endcase
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: w[31:25] = 7'h01;
      endcase
    end
    return w;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; instr = '0; instr_valid = 0; ex_ready = 1; redirect = 0;
    tick(); tick();
    rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs[k] !== 33'h0) begin errors++; $display("FAIL reset_outputs dut%0d got %h want 0", k, obs[k]); end
      checks++; if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %b want 1", k, rdy[k]); end
    end
    $display("test_reset: outputs after reset dut0 %h dut1 %h", obs[0], obs[1]);
  endtask

  task automatic test_add();
    instr = I_ADD; instr_valid = 1; ex_ready = 1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", rdy[0]); end
    tick();
    checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", vld[0]); end
    checks++; if (rw[0] !== 1'b1) begin errors++; $display("FAIL add_regwrite got %b want 1", rw[0]); end
    checks++; if (src[0] !== 1'b0) begin errors++; $display("FAIL add_alusrc got %b want 0", src[0]); end
    checks++; if (alu[0] !== 4'b0010) begin errors++; $display("FAIL add_aluctrl got %b want 0010", alu[0]); end
    checks++; if (rd[0] !== 5'd3) begin errors++; $display("FAIL add_rd got %0d want 3", rd[0]); end
    instr_valid = 0;
    tick();
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", vld[0]); end
    $display("test_add: add x3,x1,x2 decoded alu %b rd %0d", alu[0], rd[0]);
  endtask

  task automatic test_load_use();
    instr = I_LW; instr_valid = 1; ex_ready = 1;
    tick();
    checks++; if (mr[0] !== 1'b1 || rd[0] !== 5'd5) begin errors++; $display("FAIL lw_decode got mr %b rd %0d want mr 1 rd 5", mr[0], rd[0]); end
    instr = I_ADD6;
    #1;
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL loaduse_ready_hz got %b want 0", rdy[0]); end
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL loaduse_ready_nohz got %b want 1", rdy[1]); end
    tick();
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL loaduse_bubble got %b want 0", vld[0]); end
    checks++; if (vld[1] !== 1'b1 || rd[1] !== 5'd6) begin errors++; $display("FAIL loaduse_nohz got v %b rd %0d want v 1 rd 6", vld[1], rd[1]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL loaduse_ready_after got %b want 1", rdy[0]); end
    tick();
    checks++; if (vld[0] !== 1'b1 || rd[0] !== 5'd6 || alu[0] !== 4'b0010) begin
      errors++; $display("FAIL loaduse_add got v %b rd %0d alu %b want v 1 rd 6 alu 0010", vld[0], rd[0], alu[0]); end
    instr_valid = 0;
    tick();
    $display("test_load_use: bubble inserted with HAZARD_EN=1, none with HAZARD_EN=0");
  endtask

  task automatic test_branch_flush();
    instr = I_BEQ; instr_valid = 1; ex_ready = 1;
    tick();
    checks++; if (br[0] !== 1'b1 || cmp[0] !== 3'b000 || alu[0] !== 4'b0110 || rw[0] !== 1'b0) begin
      errors++; $display("FAIL beq_decode got br %b cmp %b alu %b rw %b want 1 000 0110 0", br[0], cmp[0], alu[0], rw[0]); end
    redirect = 1; instr_valid = 0;
    tick();
    redirect = 0;
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL redirect_valid got %b want 0", vld[0]); end
    instr = I_ADD; instr_valid = 1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", rdy[0]); end
    tick();
    checks++; if (vld[0] !== 1'b0 || vld[1] !== 1'b0) begin errors++; $display("FAIL flush_first got %b/%b want 0/0", vld[0], vld[1]); end
    instr = I_ADDI;
    tick();
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL flush_second got %b want 0", vld[0]); end
    checks++; if (vld[1] !== 1'b1 || rd[1] !== 5'd7) begin errors++; $display("FAIL flush1_resume got v %b rd %0d want v 1 rd 7", vld[1], rd[1]); end
    instr = I_XOR;
    tick();
    checks++; if (vld[0] !== 1'b1 || rd[0] !== 5'd8 || alu[0] !== 4'b0011) begin
      errors++; $display("FAIL flush2_resume got v %b rd %0d alu %b want v 1 rd 8 alu 0011", vld[0], rd[0], alu[0]); end
    instr_valid = 0;
    tick();
    $display("test_branch_flush: two squashed with FLUSH_CYCLES=2, one with FLUSH_CYCLES=1");
  endtask

  task automatic test_stall();
    logic [32:0] held;
    held = {1'b1, ref_decode(I_ADD, 1'b0)};
    instr = I_ADD; instr_valid = 1; ex_ready = 1;
    tick();
    ex_ready = 0; instr = I_XOR;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %b want 0", c, rdy[0]); end
      tick();
      checks++; if (obs[0] !== held) begin errors++; $display("FAIL stall_hold cyc %0d got %h want %h", c, obs[0], held); end
    end
    ex_ready = 1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", rdy[0]); end
    tick();
    checks++; if (vld[0] !== 1'b1 || rd[0] !== 5'd8) begin errors++; $display("FAIL stall_resume got v %b rd %0d want v 1 rd 8", vld[0], rd[0]); end
    instr_valid = 0;
    tick();
    $display("test_stall: bundle held 3 cycles then advanced");
  endtask

  task automatic test_illegal_mul();
    instr = I_ILL; instr_valid = 1; ex_ready = 1;
    tick();
    checks++; if (vld[0] !== 1'b1 || ill[0] !== 1'b1 || rw[0] !== 1'b0) begin
      errors++; $display("FAIL illegal_7f got v %b ill %b rw %b want 1 1 0", vld[0], ill[0], rw[0]); end
    instr = I_MUL;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL illegal_nostall got %b want 1", rdy[0]); end
    tick();
    checks++; if (ill[0] !== 1'b1 || rw[0] !== 1'b0) begin errors++; $display("FAIL mul_noext got ill %b rw %b want 1 0", ill[0], rw[0]); end
    checks++; if (alu[1] !== 4'b1010 || ill[1] !== 1'b0 || rw[1] !== 1'b1 || rd[1] !== 5'd9) begin
      errors++; $display("FAIL mul_ext got alu %b ill %b rw %b rd %0d want 1010 0 1 9", alu[1], ill[1], rw[1], rd[1]); end
    instr_valid = 0;
    tick();
    $display("test_illegal_mul: illegal propagated, mul decoded with MEXT_EN=1");
  endtask

  task automatic test_reset_mid_flush();
    instr_valid = 0; ex_ready = 1; redirect = 1;
    tick();
    redirect = 0; rst = 1; instr = I_ADD; instr_valid = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (obs[0] !== 33'h0) begin errors++; $display("FAIL rstflush_outputs got %h want 0", obs[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstflush_ready got %b want 1", rdy[0]); end
    tick();
    checks++; if (vld[0] !== 1'b1 || rd[0] !== 5'd3) begin errors++; $display("FAIL rstflush_run got v %b rd %0d want v 1 rd 3", vld[0], rd[0]); end
    instr_valid = 0;
    tick();
    $display("test_reset_mid_flush: flush abandoned by reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 99) < 2);
      redirect    = ($urandom_range(0, 99) < 6);
      ex_ready    = ($urandom_range(0, 99) < 70);
      instr_valid = ($urandom_range(0, 99) < 80);
      instr       = rand_instr();
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdy[k] !== exp_ready(k)) begin
          errors++; $display("FAIL rand_ready n %0d dut%0d got %b want %b", n, k, rdy[k], exp_ready(k)); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (m_valid[k]) begin
          if (obs[k] !== {1'b1, m_bundle[k]}) begin
            errors++; $display("FAIL rand_bundle n %0d dut%0d got %h want %h", n, k, obs[k], {1'b1, m_bundle[k]}); end
        end else if (vld[k] !== 1'b0) begin
          errors++; $display("FAIL rand_valid n %0d dut%0d got %b want 0", n, k, vld[k]);
        end
      end
      $display("rand %0d instr %h rst %b redir %b exr %b v %b/%b", n, instr, rst, redirect, ex_ready, vld[0], vld[1]);
    end
    rst = 0; redirect = 0; instr_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_branch_flush();
    test_stall();
    test_illegal_mul();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
